// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chess_pkg
// Description : Piece codes, piece values, CSR indices and evaluator FSM
//               states shared by the move generators and the board evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package chess_pkg;

    // Signed 8-bit piece codes; each kind occupies a contiguous code range
    // that starts at its *0 code and ends just below the next kind.
    localparam logic signed [7:0] EMPTY    = 8'sd0;
    localparam logic signed [7:0] WPAWN0   = 8'sd1;
    localparam logic signed [7:0] WROOK0   = 8'sd9;
    localparam logic signed [7:0] WKNIGHT0 = 8'sd19;
    localparam logic signed [7:0] WBISHOP0 = 8'sd29;
    localparam logic signed [7:0] WQUEEN0  = 8'sd39;
    localparam logic signed [7:0] WKING    = 8'sd48;
    localparam logic signed [7:0] BPAWN0   = -8'sd1;
    localparam logic signed [7:0] BROOK0   = -8'sd9;
    localparam logic signed [7:0] BKNIGHT0 = -8'sd19;
    localparam logic signed [7:0] BBISHOP0 = -8'sd29;
    localparam logic signed [7:0] BQUEEN0  = -8'sd39;
    localparam logic signed [7:0] BKING    = -8'sd48;

    localparam int PAWN_V   = 100;
    localparam int ROOK_V   = 500;
    localparam int KNIGHT_V = 300;
    localparam int BISHOP_V = 300;
    localparam int QUEEN_V  = 900;

    typedef enum logic [3:0] {
        CSR_CTRL    = 4'd0,
        CSR_SRC     = 4'd1,
        CSR_DST     = 4'd2,
        CSR_COUNT   = 4'd3,
        CSR_LAST    = 4'd4,
        CSR_INVALID = 4'd5
    } csr_idx_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_STORE     = 3'd3,
        ST_DONE      = 3'd4
    } eval_state_e;

    // Byte address of square sq of board number board in a packed board array.
    function automatic logic [31:0] square_addr(input logic [31:0] base,
                                                input logic [31:0] board,
                                                input logic [31:0] sq,
                                                input int          squares);
        return base + board * 32'(squares) + sq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : board_eval_if
// Description : CSR slave port plus SDRAM master port of the board evaluator.
//               'slave' is the accelerator's view, 'master' the system side.
// Revision    : 1.0 - initial release
// ============================================================================
interface board_eval_if;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    modport slave (
        output slave_waitrequest, slave_readdata,
        input  slave_address, slave_read, slave_write, slave_writedata,
        output master_address, master_read, master_write, master_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );

    modport master (
        input  slave_waitrequest, slave_readdata,
        output slave_address, slave_read, slave_write, slave_writedata,
        input  master_address, master_read, master_write, master_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/piece_value_lut.sv
`default_nettype none
// ============================================================================
// Module      : piece_value_lut
// Description : Maps a signed piece code to its signed material value and
//               flags codes outside the legal range.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_value_lut #(
    parameter int SCORE_W = 32
) (
    input  wire logic signed [7:0]         code,
    output logic         signed [SCORE_W-1:0] value,
    output logic                            invalid
);
    import chess_pkg::*;

    always_comb begin
        value   = '0;
        invalid = 1'b0;
        // White ranges are walked upward, black ranges mirror them downward.
        if (code >= WPAWN0) begin
            if      (code < WROOK0)   value = SCORE_W'(PAWN_V);
            else if (code < WKNIGHT0) value = SCORE_W'(ROOK_V);
            else if (code < WBISHOP0) value = SCORE_W'(KNIGHT_V);
            else if (code < WQUEEN0)  value = SCORE_W'(BISHOP_V);
            else if (code < WKING)    value = SCORE_W'(QUEEN_V);
            else if (code != WKING)   invalid = 1'b1;
        end else if (code <= BPAWN0) begin
            if      (code > BROOK0)   value = -SCORE_W'(PAWN_V);
            else if (code > BKNIGHT0) value = -SCORE_W'(ROOK_V);
            else if (code > BBISHOP0) value = -SCORE_W'(KNIGHT_V);
            else if (code > BQUEEN0)  value = -SCORE_W'(BISHOP_V);
            else if (code > BKING)    value = -SCORE_W'(QUEEN_V);
            else if (code != BKING)   invalid = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_eval.sv
`default_nettype none
// ============================================================================
// Module      : board_eval
// Description : Reads packed 64-byte boards from SDRAM, sums signed piece
//               values per board and writes one score word per board.
// Revision    : 1.0 - initial release
// ============================================================================
module board_eval #(
    parameter int SQUARES = 64,
    parameter int SCORE_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    board_eval_if.slave bus
);
    import chess_pkg::*;

    localparam int              SQ_W        = $clog2(SQUARES);
    localparam logic [SQ_W-1:0] LAST_SQ     = SQ_W'(SQUARES - 1);
    localparam logic [31:0]     INVALID_MAX = '1;

    eval_state_e               state_q, state_d;
    logic [31:0]               src_q, src_d, dst_q, dst_d, count_q, count_d;
    logic [31:0]               run_src_q, run_src_d, run_dst_q, run_dst_d;
    logic [31:0]               run_n_q, run_n_d, board_q, board_d;
    logic [SQ_W-1:0]           sq_q, sq_d;
    logic signed [SCORE_W-1:0] acc_q, acc_d, last_q, last_d;
    logic [31:0]               invalid_q, invalid_d;
    logic                      slave_wait_q, slave_wait_d;
    logic [31:0]               slave_rdata_q, slave_rdata_d;
    logic                      mread_q, mread_d, mwrite_q, mwrite_d;
    logic [31:0]               maddr_q, maddr_d, mwdata_q, mwdata_d;

    logic                      start_go;
    logic                      done_ack;
    logic signed [SCORE_W-1:0] piece_v;
    logic                      piece_invalid;
    logic signed [SCORE_W-1:0] acc_sum;
    logic [31:0]               board_next;
    logic                      unused_rdata_hi;

    piece_value_lut #(.SCORE_W(SCORE_W)) u_lut (
        .code    ($signed(bus.master_readdata[7:0])),
        .value   (piece_v),
        .invalid (piece_invalid)
    );

    assign unused_rdata_hi = ^bus.master_readdata[31:8];

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        count_d       = count_q;
        run_src_d     = run_src_q;
        run_dst_d     = run_dst_q;
        run_n_d       = run_n_q;
        board_d       = board_q;
        sq_d          = sq_q;
        acc_d         = acc_q;
        last_d        = last_q;
        invalid_d     = invalid_q;
        slave_wait_d  = slave_wait_q;
        slave_rdata_d = slave_rdata_q;
        mread_d       = mread_q;
        mwrite_d      = mwrite_q;
        maddr_d       = maddr_q;
        mwdata_d      = mwdata_q;
        start_go      = 1'b0;
        done_ack      = 1'b0;
        acc_sum       = acc_q + piece_v;
        board_next    = board_q + 32'd1;

        // CSR port: one service cycle, one acknowledge cycle, then re-arm.
        if (!slave_wait_q) begin
            slave_wait_d = 1'b1;
        end else if (bus.slave_write) begin
            slave_wait_d = 1'b0;
            case (csr_idx_e'(bus.slave_address))
                CSR_CTRL:  start_go = (state_q == ST_IDLE);
                CSR_SRC:   src_d    = bus.slave_writedata;
                CSR_DST:   dst_d    = bus.slave_writedata;
                CSR_COUNT: count_d  = bus.slave_writedata;
                default:   ;
            endcase
        end else if (bus.slave_read) begin
            slave_wait_d = 1'b0;
            case (csr_idx_e'(bus.slave_address))
                CSR_CTRL: begin
                    if (state_q == ST_DONE) begin
                        slave_rdata_d = run_n_q;
                        done_ack      = 1'b1;
                    end else if (state_q == ST_IDLE) begin
                        slave_rdata_d = board_q;
                    end else begin
                        slave_wait_d  = 1'b1;
                    end
                end
                CSR_SRC:     slave_rdata_d = src_q;
                CSR_DST:     slave_rdata_d = dst_q;
                CSR_COUNT:   slave_rdata_d = count_q;
                CSR_LAST:    slave_rdata_d = 32'(last_q);
                CSR_INVALID: slave_rdata_d = invalid_q;
                default:     slave_rdata_d = '0;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    run_src_d = src_q;
                    run_dst_d = dst_q;
                    run_n_d   = count_q;
                    board_d   = '0;
                    sq_d      = '0;
                    acc_d     = '0;
                    last_d    = '0;
                    invalid_d = '0;
                    if (count_q == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        mread_d = 1'b1;
                        maddr_d = square_addr(src_q, 32'd0, 32'd0, SQUARES);
                    end
                end
            end
            ST_FETCH: begin
                if (!bus.master_waitrequest) begin
                    mread_d = 1'b0;
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (bus.master_readdatavalid) begin
                    acc_d = acc_sum;
                    if (piece_invalid && (invalid_q != INVALID_MAX)) begin
                        invalid_d = invalid_q + 32'd1;
                    end
                    if (sq_q == LAST_SQ) begin
                        state_d  = ST_STORE;
                        mwrite_d = 1'b1;
                        maddr_d  = run_dst_q + (board_q << 2);
                        mwdata_d = 32'(acc_sum);
                    end else begin
                        sq_d    = sq_q + SQ_W'(1);
                        state_d = ST_FETCH;
                        mread_d = 1'b1;
                        maddr_d = square_addr(run_src_q, board_q,
                                              32'(sq_q) + 32'd1, SQUARES);
                    end
                end
            end
            ST_STORE: begin
                if (!bus.master_waitrequest) begin
                    mwrite_d = 1'b0;
                    last_d   = acc_q;
                    acc_d    = '0;
                    board_d  = board_next;
                    if (board_next == run_n_q) begin
                        state_d = ST_DONE;
                    end else begin
                        sq_d    = '0;
                        state_d = ST_FETCH;
                        mread_d = 1'b1;
                        maddr_d = square_addr(run_src_q, board_next, 32'd0, SQUARES);
                    end
                end
            end
            ST_DONE: begin
                if (done_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            count_q       <= '0;
            run_src_q     <= '0;
            run_dst_q     <= '0;
            run_n_q       <= '0;
            board_q       <= '0;
            sq_q          <= '0;
            acc_q         <= '0;
            last_q        <= '0;
            invalid_q     <= '0;
            slave_wait_q  <= 1'b1;
            slave_rdata_q <= '0;
            mread_q       <= 1'b0;
            mwrite_q      <= 1'b0;
            maddr_q       <= '0;
            mwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            count_q       <= count_d;
            run_src_q     <= run_src_d;
            run_dst_q     <= run_dst_d;
            run_n_q       <= run_n_d;
            board_q       <= board_d;
            sq_q          <= sq_d;
            acc_q         <= acc_d;
            last_q        <= last_d;
            invalid_q     <= invalid_d;
            slave_wait_q  <= slave_wait_d;
            slave_rdata_q <= slave_rdata_d;
            mread_q       <= mread_d;
            mwrite_q      <= mwrite_d;
            maddr_q       <= maddr_d;
            mwdata_q      <= mwdata_d;
        end
    end

    assign bus.slave_waitrequest = slave_wait_q;
    assign bus.slave_readdata    = slave_rdata_q;
    assign bus.master_read       = mread_q;
    assign bus.master_write      = mwrite_q;
    assign bus.master_address    = maddr_q;
    assign bus.master_writedata  = mwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_board_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_eval
// Description : Directed bench for board_eval with an SDRAM responder and a
//               queue of expected score writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_eval;
    import chess_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_eval_if bus();

    board_eval #(.SQUARES(64), .SCORE_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] score;
    } exp_t;

    int          checks      = 0;
    int          failures    = 0;
    int          write_count = 0;
    int          req_count   = 0;
    int          exp_invalid = 0;
    bit          stall_en    = 1'b0;
    bit          spurious    = 1'b0;
    int          rd_extra    = 0;
    logic [7:0]  mem [0:8191];
    logic [31:0] wmem [logic [31:0]];
    exp_t        sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Material value straight from the piece table, by code magnitude.
    function automatic int ref_value(input logic [7:0] c);
        int v, m, r;
        v = int'($signed(c));
        m = (v < 0) ? -v : v;
        if (m == 0 || m >= 48) r = 0;
        else if (m <= 8)       r = 100;
        else if (m <= 18)      r = 500;
        else if (m <= 38)      r = 300;
        else                   r = 900;
        return (v < 0) ? -r : r;
    endfunction

    function automatic int ref_invalid(input logic [7:0] c);
        int v;
        v = int'($signed(c));
        return (v > 48 || v < -48) ? 1 : 0;
    endfunction

    task automatic clear_board(input int base);
        for (int s = 0; s < 64; s++) mem[base + s] = 8'h00;
    endtask

    task automatic expect_board(input int src, input int b, input logic [31:0] dst);
        exp_t e;
        int   sum;
        sum = 0;
        for (int s = 0; s < 64; s++) begin
            sum         += ref_value(mem[src + 64*b + s]);
            exp_invalid += ref_invalid(mem[src + 64*b + s]);
        end
        e.addr  = dst + 32'(4*b);
        e.score = 32'(sum);
        sb_q.push_back(e);
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!bus.slave_waitrequest) done = 1'b1;
        end
        bus.slave_write = 1'b0;
        check("csr_write_ack", {31'd0, done}, 32'd1);
    endtask

    task automatic csr_read(input logic [3:0] a, input int budget,
                            output logic [31:0] data, output int cyc);
        bit done;
        done = 1'b0;
        data = 32'hDEAD_BEEF;
        cyc  = 0;
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (!bus.slave_waitrequest) begin
                done = 1'b1;
                data = bus.slave_readdata;
            end
        end
        bus.slave_read = 1'b0;
        check("csr_read_ack", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input logic [31:0] src, input logic [31:0] dst, input int n,
                       input int budget, output logic [31:0] ret);
        int cyc;
        exp_invalid = 0;
        for (int b = 0; b < n; b++) expect_board(int'(src), b, dst);
        csr_write(4'd1, src);
        csr_write(4'd2, dst);
        csr_write(4'd3, 32'(n));
        csr_write(4'd0, 32'd1);
        csr_read(4'd0, budget, ret, cyc);
        check("run_pending_writes", 32'(sb_q.size()), 32'd0);
    endtask

    // SDRAM responder: inputs change on the falling edge only.
    initial begin
        bit          in_req;
        int          stall_left;
        logic [31:0] held_addr;
        logic        held_wr;
        bit          rd_pending;
        int          rd_delay;
        logic [31:0] rd_word;
        logic [23:0] junk;
        exp_t        e;
        in_req = 0; stall_left = 0; held_addr = '0; held_wr = 1'b0;
        rd_pending = 0; rd_delay = 0; rd_word = '0;
        bus.master_waitrequest   = 1'b1;
        bus.master_readdata      = '0;
        bus.master_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = 1'b0;
            if (!rst_n) begin
                in_req = 0; stall_left = 0; rd_pending = 0;
                bus.master_waitrequest = 1'b1;
            end else begin
                if (rd_pending) begin
                    if (rd_delay == 0) begin
                        bus.master_readdatavalid = 1'b1;
                        bus.master_readdata      = rd_word;
                        rd_pending               = 0;
                    end else begin
                        rd_delay--;
                    end
                end
                if (bus.master_read || bus.master_write) begin
                    if (!in_req) begin
                        in_req    = 1;
                        req_count++;
                        held_addr = bus.master_address;
                        held_wr   = bus.master_write;
                        if (!stall_en)             stall_left = 0;
                        else if (bus.master_write) stall_left = 5;
                        else                       stall_left = ($urandom_range(0, 2) == 0) ? 5 : 0;
                    end else begin
                        check("addr_stable", bus.master_address, held_addr);
                        check("kind_stable", {31'd0, bus.master_write}, {31'd0, held_wr});
                    end
                    if (stall_left > 0) begin
                        bus.master_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        bus.master_waitrequest = 1'b0;
                        in_req = 0;
                        if (bus.master_write) begin
                            write_count++;
                            wmem[bus.master_address] = bus.master_writedata;
                            if (sb_q.size() == 0) begin
                                checks++;
                                failures++;
                                $error("FAIL unexpected_write addr=0x%08h data=0x%08h",
                                       bus.master_address, bus.master_writedata);
                            end else begin
                                e = sb_q.pop_front();
                                check("wr_addr", bus.master_address, e.addr);
                                check("wr_score", bus.master_writedata, e.score);
                            end
                        end else begin
                            junk       = 24'($urandom());
                            rd_word    = {junk, mem[bus.master_address[12:0]]};
                            rd_pending = 1;
                            rd_delay   = rd_extra;
                            if (spurious) begin
                                bus.master_readdatavalid = 1'b1;
                                bus.master_readdata      = {junk, 8'h27};
                            end
                        end
                    end
                end else begin
                    bus.master_waitrequest = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc, req0, wc0;
        logic [7:0]  home [0:7];
        bus.slave_address   = '0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_slave_wait", {31'd0, bus.slave_waitrequest}, 32'd1);
        check("rst_master_read", {31'd0, bus.master_read}, 32'd0);
        check("rst_master_write", {31'd0, bus.master_write}, 32'd0);
        check("rst_master_addr", bus.master_address, 32'd0);
        check("rst_master_wdata", bus.master_writedata, 32'd0);
        check("rst_slave_rdata", bus.slave_readdata, 32'd0);
        rst_n = 1'b1;
        csr_read(4'd0, 3, rd, cyc);
        check("idle_ctrl_read", rd, 32'd0);
        check("idle_ctrl_fast", {31'd0, cyc <= 3}, 32'd1);
        csr_read(4'd5, 3, rd, cyc);
        check("rst_invalid_cnt", rd, 32'd0);

        // Standard initial position
        home[0] = WROOK0; home[1] = WKNIGHT0; home[2] = WBISHOP0; home[3] = WQUEEN0;
        home[4] = WKING;  home[5] = 8'd30;    home[6] = 8'd20;    home[7] = 8'd10;
        for (int f = 0; f < 8; f++) begin
            mem[f]      = home[f];
            mem[8 + f]  = 8'(f + 1);
            mem[48 + f] = 8'(-(f + 1));
            mem[56 + f] = -home[f];
        end
        run(32'h0, 32'h100, 1, 1000, rd);
        check("init_ctrl_ret", rd, 32'd1);
        check("init_word", wmem.exists(32'h100) ? wmem[32'h100] : 32'hDEAD_BEEF, 32'd0);
        csr_read(4'd5, 3, rd, cyc);
        check("init_invalid", rd, 32'd0);

        // Queen versus knight
        clear_board(32'h40);
        mem[32'h40 + 3]  = WQUEEN0;
        mem[32'h40 + 57] = BKNIGHT0;
        run(32'h40, 32'h180, 1, 1000, rd);
        check("qn_ctrl_ret", rd, 32'd1);
        check("qn_word", wmem.exists(32'h180) ? wmem[32'h180] : 32'hDEAD_BEEF, 32'h258);
        csr_read(4'd4, 3, rd, cyc);
        check("qn_last_score", rd, 32'd600);

        // Read-only CSR writes are acknowledged and ignored; holes read 0
        csr_write(4'd4, 32'h1234_5678);
        csr_read(4'd4, 3, rd, cyc);
        check("ro_last_kept", rd, 32'd600);
        csr_read(4'd9, 3, rd, cyc);
        check("hole_reads_zero", rd, 32'd0);
        csr_read(4'd1, 3, rd, cyc);
        check("src_readback", rd, 32'h40);

        // Two boards, last-square pawn on the second
        clear_board(32'h80);
        clear_board(32'hC0);
        mem[32'h80 + 5]  = BROOK0;
        mem[32'hC0 + 63] = WPAWN0;
        run(32'h80, 32'h200, 2, 2000, rd);
        check("two_ctrl_ret", rd, 32'd2);
        check("two_word0", wmem.exists(32'h200) ? wmem[32'h200] : 32'hDEAD_BEEF, 32'hFFFF_FE0C);
        check("two_word1", wmem.exists(32'h204) ? wmem[32'h204] : 32'hDEAD_BEEF, 32'h64);
        csr_read(4'd4, 3, rd, cyc);
        check("two_last_score", rd, 32'h64);

        // Out-of-range codes
        clear_board(32'h100);
        mem[32'h100 + 10] = 8'h40;
        mem[32'h100 + 20] = 8'hB0;
        run(32'h100, 32'h280, 1, 1000, rd);
        check("inv_word", wmem.exists(32'h280) ? wmem[32'h280] : 32'hDEAD_BEEF, 32'd0);
        csr_read(4'd5, 3, rd, cyc);
        check("inv_count", rd, 32'd2);
        check("inv_count_model", rd, 32'(exp_invalid));

        // Zero boards: no master traffic, quick completion
        req0 = req_count;
        csr_write(4'd3, 32'd0);
        csr_write(4'd0, 32'd1);
        csr_read(4'd0, 3, rd, cyc);
        check("n0_ctrl_ret", rd, 32'd0);
        repeat (5) @(negedge clk);
        check("n0_no_traffic", 32'(req_count - req0), 32'd0);

        // Stalls, delayed readdatavalid and a spurious valid on accept
        stall_en = 1'b1;
        spurious = 1'b1;
        rd_extra = 3;
        run(32'h40, 32'h300, 1, 4000, rd);
        check("stall_ctrl_ret", rd, 32'd1);
        check("stall_word", wmem.exists(32'h300) ? wmem[32'h300] : 32'hDEAD_BEEF, 32'h258);
        stall_en = 1'b0;
        spurious = 1'b0;
        rd_extra = 0;

        // Reset in the middle of a board
        csr_write(4'd1, 32'h0);
        csr_write(4'd2, 32'h380);
        csr_write(4'd3, 32'd1);
        csr_write(4'd0, 32'd1);
        repeat (40) @(negedge clk);
        wc0   = write_count;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_read_low", {31'd0, bus.master_read}, 32'd0);
        check("mid_rst_write_low", {31'd0, bus.master_write}, 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("mid_rst_no_write", 32'(write_count - wc0), 32'd0);
        csr_read(4'd4, 3, rd, cyc);
        check("mid_rst_last_zero", rd, 32'd0);
        run(32'h40, 32'h380, 1, 1000, rd);
        check("rerun_ctrl_ret", rd, 32'd1);
        check("rerun_word", wmem.exists(32'h380) ? wmem[32'h380] : 32'hDEAD_BEEF, 32'h258);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
